div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port flush, input, 1, which abandons any in-flight operation.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the request fields are valid.
REQ-006 The block SHALL have port in_ready, output, 1, asserted when a request can be accepted.
REQ-007 The block SHALL have ports data_a and data_b, input, XLEN each: dividend and divisor.
REQ-008 The block SHALL have port div_signed, input, 1: 1 = signed op, 0 = unsigned op.
REQ-009 The block SHALL have port div_rem, input, 1: 1 = return remainder, 0 = return quotient.
REQ-010 The block SHALL have port alu_result_size, input, 1: 1 = 32-bit word op on bits [31:0].
REQ-011 The block SHALL have port out_valid, output, 1: result is valid.
REQ-012 The block SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 The block SHALL have port result, output, XLEN: quotient or remainder.
REQ-014 The block SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 The block SHALL use three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL equal (state==IDLE) and not flush.
REQ-017 Acceptance SHALL occur when in_valid and in_ready are both high; the block then latches operands and mode bits.
REQ-018 On acceptance the block SHALL take absolute values of the operands when signed and record the quotient and remainder signs.
REQ-019 On acceptance of a normal case the block SHALL go IDLE->CALC.
REQ-020 CALC SHALL perform one restoring shift-subtract step per cycle: 64 steps for full-width ops, 32 steps for word ops.
REQ-021 After the last step the block SHALL go CALC->DONE; latency from acceptance to out_valid is 65 cycles full-width and 33 cycles word.
REQ-022 Divide by zero SHALL give quotient = all ones and remainder = dividend, with no CALC phase: IDLE->DONE, out_valid on the next cycle.
REQ-023 Signed overflow (dividend = most negative, divisor = -1) SHALL give quotient = dividend and remainder = 0, taking the same one-cycle path as REQ-022.
REQ-024 A signed quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-025 Word ops SHALL sign-extend the 32-bit result to XLEN; the special-case values in REQ-022 and REQ-023 are computed at 32 bits and then sign-extended.
REQ-026 In DONE, out_valid SHALL be high and result SHALL be held stable until out_ready.
REQ-027 DONE with out_ready SHALL go to IDLE on the next edge; no new request is accepted in that same cycle.
REQ-028 flush SHALL force IDLE on the next edge from any state and drop out_valid; flush wins over a simultaneous in_valid or out_ready.
REQ-029 Operand inputs SHALL be ignored outside acceptance; changing them during CALC has no effect.

Reset
REQ-030 reset SHALL have priority over flush and over the handshakes.
REQ-031 On reset the block SHALL force state = IDLE, out_valid = 0, result = 0, busy = 0 and the iteration counter = 0.
REQ-032 Reset asserted mid-CALC SHALL discard the operation, with no out_valid afterwards.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE = 0, CALC = 1, DONE = 2), XLEN, and the iteration counts 64 and 32.
REQ-034 One combinational sub-module, div_step, SHALL compute a single restoring step (partial remainder and divisor in; next partial remainder and quotient bit out).

Verification
REQ-035 The bench SHALL check: signed 64-bit -7 / 2, quotient -> result = -3, out_valid exactly 65 cycles after acceptance; the same with div_rem=1 -> result = -1.
REQ-036 The bench SHALL check: unsigned 64-bit 100 / 0 -> quotient 0xFFFF_FFFF_FFFF_FFFF, and with div_rem=1 -> 100, each out_valid 1 cycle after acceptance.
REQ-037 The bench SHALL check: signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-038 The bench SHALL check: word signed 0x0000_0000_8000_0000 / 1 -> result 0xFFFF_FFFF_8000_0000, out_valid 33 cycles after acceptance.
REQ-039 The bench SHALL check: out_ready held low for 10 cycles in DONE -> result stable and in_ready low throughout; out_ready high -> IDLE next cycle.
REQ-040 The bench SHALL check: flush at CALC cycle 20 together with in_valid -> request not accepted, IDLE next cycle, no out_valid; the next request completes correctly.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding, width and iteration counts for the sequential divider
package div_seq_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int ITER_FULL = 64;
    localparam int ITER_WORD = 32;
    localparam int CNT_W     = 7;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step of the divider
module div_step
    import div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    assign shifted = {rem, bit_in};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider with signed/unsigned, quotient/remainder and 32-bit word modes
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] data_a,
    input  logic [XLEN-1:0] data_b,
    input  logic            div_signed,
    input  logic            div_rem,
    input  logic            alu_result_size,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(ITER_FULL - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ITER_WORD - 1);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  rem_q, quo_q, div_q, result_q;
    logic [CNT_W-1:0] cnt;
    logic             is_word, is_rem, q_neg, r_neg;
    logic             accept, a_neg, b_neg, div_zero, overflow, special, last, q_bit;
    logic [XLEN-1:0]  a_sx, a_ext, b_ext, a_abs, b_abs, min_neg, special_val;
    logic [XLEN-1:0]  rem_nxt, quo_nxt, q_mag, fin, fin_ext;

    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_q;

    // Word ops work on the low 32 bits, extended according to signedness
    assign a_sx  = alu_result_size ? {{(XLEN-32){data_a[31]}}, data_a[31:0]} : data_a;
    assign a_ext = (alu_result_size && !div_signed) ? {{(XLEN-32){1'b0}}, data_a[31:0]} : a_sx;
    assign b_ext = alu_result_size ? (div_signed ? {{(XLEN-32){data_b[31]}}, data_b[31:0]}
                                                 : {{(XLEN-32){1'b0}}, data_b[31:0]}) : data_b;
    assign a_neg = div_signed && a_ext[XLEN-1];
    assign b_neg = div_signed && b_ext[XLEN-1];
    assign a_abs = a_neg ? -a_ext : a_ext;
    assign b_abs = b_neg ? -b_ext : b_ext;
    assign min_neg = alu_result_size ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = (b_ext == '0);
    assign overflow = div_signed && (a_ext == min_neg) && (b_ext == '1);
    assign special  = div_zero || overflow;
    assign special_val = div_zero ? (div_rem ? a_sx : '1) : (div_rem ? '0 : a_sx);

    div_step #(.XLEN(XLEN)) u_step (
        .rem    (rem_q),
        .bit_in (quo_q[XLEN-1]),
        .divisor(div_q),
        .rem_out(rem_nxt),
        .q_bit  (q_bit)
    );

    assign quo_nxt = {quo_q[XLEN-2:0], q_bit};
    assign last    = (cnt == (is_word ? LAST_WORD : LAST_FULL));
    assign q_mag   = is_word ? {{(XLEN-32){1'b0}}, quo_nxt[31:0]} : quo_nxt;
    assign fin     = is_rem ? (r_neg ? -rem_nxt : rem_nxt) : (q_neg ? -q_mag : q_mag);
    assign fin_ext = is_word ? {{(XLEN-32){fin[31]}}, fin[31:0]} : fin;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = accept ? (special ? DONE : CALC) : IDLE;
                CALC:    state_nxt = last ? DONE : CALC;
                DONE:    state_nxt = out_ready ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge clock)
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;

    // Word ops park the dividend in the upper half so 32 steps consume exactly its bits
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            result_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            is_word  <= 1'b0;
            is_rem   <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (accept) begin
            is_word <= alu_result_size;
            is_rem  <= div_rem;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            div_q   <= b_abs;
            rem_q   <= '0;
            quo_q   <= alu_result_size ? (a_abs << 32) : a_abs;
            cnt     <= '0;
            if (special)
                result_q <= special_val;
        end else if (state == CALC && !flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (last)
                result_q <= fin_ext;
        end
    end
endmodule
